// File: rtl/pll_reconfig_seq.sv
// Sequencer that programs a PLL through its reconfig management port and waits for relock.
// Optional lock-wait timeout is enabled by defining PLL_RECONFIG_TIMEOUT_EN.
module pll_reconfig_seq #(
  parameter int NUM_CH      = 1,
  parameter int LOCK_SETTLE = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [31:0]           cfg_n,
  input  logic [31:0]           cfg_m,
  input  logic [31:0]           cfg_k,
  input  logic [32*NUM_CH-1:0]  cfg_c,
  output logic [5:0]            mgmt_address,
  output logic                  mgmt_write,
  output logic [31:0]           mgmt_writedata,
  input  logic                  mgmt_waitrequest,
  input  logic                  pll_locked,
  output logic                  done,
  output logic                  error
);

  localparam int CH_W = 4;

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_N, WR_M, WR_K, WR_C, WR_START, SETTLE, WAIT_LOCK
  } state_e;

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [7:0]             settle_q, settle_d;
  logic [31:0]            n_q, m_q, k_q;
  logic [18*NUM_CH-1:0]   c_q, c_lo;
  logic [14*NUM_CH-1:0]   c_hi;
  logic                   unused_c_hi;
  logic [17:0]            c_sel;
  logic                   write_q, write_d;
  logic [5:0]             addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   accept;

`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]        to_q, to_d;
  logic                   error_q, error_d;
`endif

  assign accept = cfg_valid && ready_q;

  // Only the 18 counter bits of each channel word are programmed.
  always_comb begin
    c_lo = '0;
    c_hi = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c_lo[18*i +: 18] = cfg_c[32*i +: 18];
      c_hi[14*i +: 14] = cfg_c[32*i+18 +: 14];
    end
  end
  assign unused_c_hi = ^c_hi;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    settle_d = settle_q;
    done_d   = 1'b0;
`ifdef PLL_RECONFIG_TIMEOUT_EN
    to_d    = (state_q == WAIT_LOCK) ? to_q : '0;
    error_d = error_q;
`endif
    unique case (state_q)
      IDLE:     if (accept) state_d = WR_MODE;
      WR_MODE:  if (!mgmt_waitrequest) state_d = WR_N;
      WR_N:     if (!mgmt_waitrequest) state_d = WR_M;
      WR_M:     if (!mgmt_waitrequest) state_d = WR_K;
      WR_K: begin
        if (!mgmt_waitrequest) begin
          state_d = WR_C;
          ch_d    = '0;
        end
      end
      WR_C: begin
        if (!mgmt_waitrequest) begin
          if (ch_q == CH_W'(NUM_CH - 1)) state_d = WR_START;
          else ch_d = ch_q + 1'b1;
        end
      end
      WR_START: begin
        if (!mgmt_waitrequest) begin
          state_d  = SETTLE;
          settle_d = 8'(LOCK_SETTLE - 1);
        end
      end
      SETTLE: begin
        if (settle_q == 8'd0) state_d = WAIT_LOCK;
        else settle_d = settle_q - 8'd1;
      end
      WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef PLL_RECONFIG_TIMEOUT_EN
          error_d = 1'b0;
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_d == CH_W'(i)) c_sel = c_q[18*i +: 18];
  end

  // Bus outputs are decoded from the upcoming state so they are registered alongside it.
  always_comb begin
    write_d = 1'b0;
    addr_d  = 6'd0;
    data_d  = 32'd0;
    ready_d = (state_d == IDLE);
    unique case (state_d)
      WR_MODE:  write_d = 1'b1;
      WR_N:     begin write_d = 1'b1; addr_d = 6'd3; data_d = n_q; end
      WR_M:     begin write_d = 1'b1; addr_d = 6'd4; data_d = m_q; end
      WR_K:     begin write_d = 1'b1; addr_d = 6'd7; data_d = k_q; end
      WR_C:     begin write_d = 1'b1; addr_d = 6'd5; data_d = {9'b0, 5'(ch_d), c_sel}; end
      WR_START: begin write_d = 1'b1; addr_d = 6'd2; data_d = 32'd1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      settle_q <= '0;
      n_q      <= '0;
      m_q      <= '0;
      k_q      <= '0;
      c_q      <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef PLL_RECONFIG_TIMEOUT_EN
      to_q     <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      settle_q <= settle_d;
      if (accept) begin
        n_q <= cfg_n;
        m_q <= cfg_m;
        k_q <= cfg_k;
        c_q <= c_lo;
      end
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef PLL_RECONFIG_TIMEOUT_EN
      to_q     <= to_d;
      error_q  <= error_d;
`endif
    end
  end

  assign cfg_ready      = ready_q;
  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign done           = done_q;
`ifdef PLL_RECONFIG_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
